sum_uart_tx: RTL and testbench
==============================

SUM_UART_TX -- requirements
Module: sum_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit period (legal range 2..1023).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port a  input  8  first operand, sampled only on accepted start.
REQ-006 Port b  input  8  second operand, sampled only on accepted start.
REQ-007 Port start  input  1  request to compute a+b and transmit; level sampled each cycle.
REQ-008 Port tx  output  1  serial line, idle high, 8N1 frame, LSB first.
REQ-009 Port busy  output  1  high from the cycle after accepted start until the frame completes.
REQ-010 Port done  output  1  single-cycle pulse at frame completion.
REQ-011 Port carry  output  1  bit 8 of the latched sum, held until the next accepted start.

Function
REQ-012 The block SHALL implement states IDLE, START, DATA, STOP.
REQ-013 In IDLE with start=1, the block SHALL latch sum = a+b as a 9-bit zero-extended result, latch carry=sum[8], and enter START next cycle.
REQ-014 In any state other than IDLE, start SHALL be ignored: no relatch, no restart, and no effect on carry.
REQ-015 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-016 DATA SHALL drive sum[0]..sum[7] in order, each for exactly CLKS_PER_BIT cycles, using a 3-bit index that reaches 7 and then exits to STOP without wrapping.
REQ-017 STOP SHALL drive tx=1 for exactly CLKS_PER_BIT cycles, then return to IDLE.
REQ-018 The frame SHALL last exactly 10*CLKS_PER_BIT cycles, measured from the first tx=0 cycle to the first IDLE cycle.
REQ-019 The bit timer SHALL count 0..CLKS_PER_BIT-1 and reset to 0 at every bit boundary and state change.
REQ-020 done SHALL assert for exactly one cycle, in the cycle the state returns to IDLE; busy SHALL be 0 in that same cycle.
REQ-021 tx SHALL be registered and glitch-free, and SHALL be 1 in IDLE.
REQ-022 If start is held high continuously, a new frame SHALL be accepted in the done cycle, giving back-to-back frames with no idle gap beyond that one cycle.
REQ-023 Operand overflow (a+b>255) SHALL transmit sum[7:0] and set carry=1; no saturation SHALL occur.

Reset
REQ-024 While rst=1, the block SHALL force state=IDLE, tx=1, busy=0, done=0, carry=0, and clear the bit timer, bit index and latched sum.
REQ-025 Reset asserted mid-frame SHALL abort the frame on the next edge (tx=1 immediately after), and SHALL NOT produce a done pulse.
REQ-026 start asserted together with rst SHALL be ignored, and the first acceptance SHALL occur no earlier than the first cycle after rst deasserts.

Verification
REQ-027 With CLKS_PER_BIT=4, a=8'h12, b=8'h23, and a 1-cycle start, the bench SHALL check that tx carries 0, then 1,0,1,0,1,1,0,0 (8'h35, LSB first), then 1, with each bit lasting 4 cycles, carry=0, and done pulsing exactly once 40 cycles after the first 0.
REQ-028 With a=8'hFF and b=8'h02, the bench SHALL check that the frame byte is 8'h01, carry=1, and carry stays 1 through the following IDLE.
REQ-029 The bench SHALL pulse start again in mid-DATA with different operands and check that the frame is unchanged, carry is unchanged, and only one done pulse occurs.
REQ-030 The bench SHALL hold start=1 for 3 frames and check 3 consecutive frames separated by exactly one idle-high cycle, with 3 done pulses.
REQ-031 The bench SHALL assert rst during DATA bit 3 and check that tx=1, busy=0, carry=0 on the next cycle, that no done pulse occurs, and that a subsequent start produces a correct full frame.
REQ-032 The bench SHALL decode each frame with a mid-bit-sampling UART reference model and compare it against a+b for 200 random operand pairs at CLKS_PER_BIT=16.

Source files
------------

// File: rtl/sum_uart_tx.sv
// Adds two 8-bit operands and sends the low byte of the sum as one 8N1 UART
// frame (LSB first, idle high). The ninth sum bit is kept on carry until the
// next accepted start.
module sum_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       start,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       carry
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_t;

    // Wide enough for the largest legal bit period (1023 clocks).
    localparam int unsigned TimerW = 10;
    localparam logic [TimerW-1:0] LastTick = TimerW'(CLKS_PER_BIT - 1);

    state_t            r_state;
    state_t            w_state_d;
    logic [TimerW-1:0] r_timer;
    logic [TimerW-1:0] w_timer_d;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_d;
    logic [7:0]        r_data;
    logic [7:0]        w_data_d;
    logic              r_carry;
    logic              w_carry_d;
    logic              r_tx;
    logic              w_tx_d;
    logic              r_busy;
    logic              w_busy_d;
    logic              r_done;
    logic              w_done_d;

    logic [8:0]        w_sum;
    logic              w_bit_end;
    logic [2:0]        w_idx_inc;

    assign w_sum     = {1'b0, a} + {1'b0, b};
    assign w_bit_end = (r_timer == LastTick);
    assign w_idx_inc = r_idx + 3'd1;

    // Next-state and next-output logic; tx/busy/done are computed for the
    // state being entered so the registered outputs line up with the state.
    always_comb begin
        w_state_d = r_state;
        w_timer_d = r_timer + 1'b1;
        w_idx_d   = r_idx;
        w_data_d  = r_data;
        w_carry_d = r_carry;
        w_tx_d    = 1'b1;
        w_busy_d  = 1'b1;
        w_done_d  = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_timer_d = '0;
                w_idx_d   = '0;
                w_busy_d  = 1'b0;
                if (start) begin
                    w_data_d  = w_sum[7:0];
                    w_carry_d = w_sum[8];
                    w_state_d = StStart;
                    w_tx_d    = 1'b0;
                    w_busy_d  = 1'b1;
                end
            end

            StStart: begin
                w_tx_d = 1'b0;
                if (w_bit_end) begin
                    w_timer_d = '0;
                    w_idx_d   = '0;
                    w_state_d = StData;
                    w_tx_d    = r_data[0];
                end
            end

            StData: begin
                w_tx_d = r_data[r_idx];
                if (w_bit_end) begin
                    w_timer_d = '0;
                    if (r_idx == 3'd7) begin
                        // Last data bit done: leave without wrapping the index.
                        w_state_d = StStop;
                        w_tx_d    = 1'b1;
                    end else begin
                        w_idx_d = w_idx_inc;
                        w_tx_d  = r_data[w_idx_inc];
                    end
                end
            end

            StStop: begin
                w_tx_d = 1'b1;
                if (w_bit_end) begin
                    w_timer_d = '0;
                    w_state_d = StIdle;
                    w_busy_d  = 1'b0;
                    w_done_d  = 1'b1;
                end
            end

            default: begin
                w_state_d = StIdle;
                w_timer_d = '0;
                w_idx_d   = '0;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; synchronous reset aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_timer <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_carry <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_timer <= w_timer_d;
            r_idx   <= w_idx_d;
            r_data  <= w_data_d;
            r_carry <= w_carry_d;
            r_tx    <= w_tx_d;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
        end
    end

    assign tx    = r_tx;
    assign busy  = r_busy;
    assign done  = r_done;
    assign carry = r_carry;

endmodule

// File: tb/tb_sum_uart_tx.sv
// Bench for sum_uart_tx: directed frame checks on a 4-clock-per-bit instance
// and a mid-bit-sampling UART decode of random sums on a 16-clock instance.
module tb_sum_uart_tx;

    localparam int unsigned CPB_S = 4;
    localparam int unsigned CPB_L = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_s, b_s, a_l, b_l;
    logic       start_s, start_l;
    logic       tx_s, busy_s, done_s, carry_s;
    logic       tx_l, busy_l, done_l, carry_l;

    int checks = 0;
    int errors = 0;

    // Captured DUT behaviour and the expected behaviour, one entry per cycle.
    logic cap_tx[$], cap_busy[$], cap_done[$], cap_carry[$];
    logic exp_tx[$], exp_busy[$], exp_done[$];

    always #5 clk = ~clk;

    sum_uart_tx #(.CLKS_PER_BIT(CPB_S)) u_dut_s (
        .clk  (clk),
        .rst  (rst),
        .a    (a_s),
        .b    (b_s),
        .start(start_s),
        .tx   (tx_s),
        .busy (busy_s),
        .done (done_s),
        .carry(carry_s)
    );

    sum_uart_tx #(.CLKS_PER_BIT(CPB_L)) u_dut_l (
        .clk  (clk),
        .rst  (rst),
        .a    (a_l),
        .b    (b_l),
        .start(start_l),
        .tx   (tx_l),
        .busy (busy_l),
        .done (done_l),
        .carry(carry_l)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void clear_all();
        cap_tx.delete(); cap_busy.delete(); cap_done.delete(); cap_carry.delete();
        exp_tx.delete(); exp_busy.delete(); exp_done.delete();
    endfunction

    // Reference frame: start bit, 8 data bits LSB first, stop bit, each CPB_S long.
    function automatic void model_frame(input logic [7:0] d);
        for (int j = 0; j < 10; j++) begin
            logic v;
            v = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : d[j-1];
            for (int c = 0; c < int'(CPB_S); c++) begin
                exp_tx.push_back(v); exp_busy.push_back(1'b1); exp_done.push_back(1'b0);
            end
        end
        exp_tx.push_back(1'b1); exp_busy.push_back(1'b0); exp_done.push_back(1'b1);
    endfunction

    function automatic void model_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_tx.push_back(1'b1); exp_busy.push_back(1'b0); exp_done.push_back(1'b0);
        end
    endfunction

    // Index of the first cycle where capture and model disagree, -1 if none.
    function automatic int first_diff();
        int n;
        n = (cap_tx.size() < exp_tx.size()) ? cap_tx.size() : exp_tx.size();
        for (int i = 0; i < n; i++)
            if (cap_tx[i] !== exp_tx[i] || cap_busy[i] !== exp_busy[i] ||
                cap_done[i] !== exp_done[i])
                return i;
        if (cap_tx.size() != exp_tx.size()) return n;
        return -1;
    endfunction

    function automatic int count_ones(input logic q[$]);
        int n = 0;
        foreach (q[i]) if (q[i] === 1'b1) n++;
        return n;
    endfunction

    // Records n cycles of the small DUT; optionally pulses start with new
    // operands at pulse_at, or drops a held start at release_at.
    task automatic capture(input int n, input int pulse_at, input logic [7:0] pa,
                           input logic [7:0] pb, input int release_at);
        for (int i = 0; i < n; i++) begin
            cap_tx.push_back(tx_s); cap_busy.push_back(busy_s);
            cap_done.push_back(done_s); cap_carry.push_back(carry_s);
            if (i == pulse_at) begin
                a_s = pa; b_s = pb; start_s = 1'b1;
            end else if (i == pulse_at + 1 || i == release_at) begin
                start_s = 1'b0;
            end
            tick();
        end
    endtask

    task automatic kick_s(input logic [7:0] av, input logic [7:0] bv);
        a_s = av; b_s = bv; start_s = 1'b1;
        tick();
        start_s = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_s = 1'b1; start_l = 1'b1;
        a_s = 8'hFF; b_s = 8'hFF; a_l = 8'hFF; b_l = 8'hFF;
        tick(); tick();
        checks++; if (tx_s !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx_s); end
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_s); end
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_s); end
        checks++; if (carry_s !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", carry_s); end
        checks++; if (tx_l !== 1'b1) begin errors++; $display("FAIL reset_tx_l got %b want 1", tx_l); end
        rst = 1'b0; start_s = 1'b0; start_l = 1'b0;
        tick();
        checks++;
        if (tx_s !== 1'b1 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL start_during_rst tx/busy got %b/%b want 1/0", tx_s, busy_s);
        end
    endtask

    task automatic test_basic();
        int idx, dpos;
        clear_all();
        kick_s(8'h12, 8'h23);
        capture(42, -10, 8'h00, 8'h00, -10);
        model_frame(8'h35); model_idle(1);
        idx = first_diff();
        checks++;
        if (idx != -1) begin
            errors++;
            $display("FAIL basic_wave cycle %0d tx/busy/done got %b%b%b want %b%b%b", idx,
                     cap_tx[idx], cap_busy[idx], cap_done[idx], exp_tx[idx], exp_busy[idx],
                     exp_done[idx]);
        end
        dpos = -1;
        foreach (cap_done[i]) if (cap_done[i] === 1'b1 && dpos < 0) dpos = i;
        checks++;
        if (dpos != 10 * int'(CPB_S) || count_ones(cap_done) != 1) begin
            errors++;
            $display("FAIL basic_done first at %0d count %0d want at %0d count 1", dpos,
                     count_ones(cap_done), 10 * CPB_S);
        end
        checks++;
        if (count_ones(cap_carry) != 0) begin
            errors++;
            $display("FAIL basic_carry high cycles %0d want 0", count_ones(cap_carry));
        end
    endtask

    task automatic test_overflow();
        int idx;
        clear_all();
        kick_s(8'hFF, 8'h02);
        capture(43, -10, 8'h00, 8'h00, -10);
        model_frame(8'h01); model_idle(2);
        idx = first_diff();
        checks++;
        if (idx != -1) begin
            errors++;
            $display("FAIL overflow_wave cycle %0d tx/busy/done got %b%b%b want %b%b%b", idx,
                     cap_tx[idx], cap_busy[idx], cap_done[idx], exp_tx[idx], exp_busy[idx],
                     exp_done[idx]);
        end
        checks++;
        if (count_ones(cap_carry) != cap_carry.size()) begin
            errors++;
            $display("FAIL overflow_carry high cycles %0d want %0d", count_ones(cap_carry),
                     cap_carry.size());
        end
    endtask

    task automatic test_midframe_start();
        int idx;
        clear_all();
        kick_s(8'h40, 8'h05);
        // Cycle 18 is inside the data phase; FF+FF would set carry if relatched.
        capture(43, 18, 8'hFF, 8'hFF, -10);
        model_frame(8'h45); model_idle(2);
        idx = first_diff();
        checks++;
        if (idx != -1) begin
            errors++;
            $display("FAIL midstart_wave cycle %0d tx/busy/done got %b%b%b want %b%b%b", idx,
                     cap_tx[idx], cap_busy[idx], cap_done[idx], exp_tx[idx], exp_busy[idx],
                     exp_done[idx]);
        end
        checks++;
        if (count_ones(cap_carry) != 0) begin
            errors++;
            $display("FAIL midstart_carry high cycles %0d want 0", count_ones(cap_carry));
        end
        checks++;
        if (count_ones(cap_done) != 1) begin
            errors++;
            $display("FAIL midstart_done count %0d want 1", count_ones(cap_done));
        end
    endtask

    task automatic test_back_to_back();
        int idx;
        int fl;
        clear_all();
        fl = 10 * int'(CPB_S) + 1;
        a_s = 8'h5A; b_s = 8'h21; start_s = 1'b1;
        tick();
        // Drop start in the third done cycle so no fourth frame begins.
        capture(3 * fl + 2, -10, 8'h00, 8'h00, 3 * fl - 1);
        for (int f = 0; f < 3; f++) model_frame(8'h7B);
        model_idle(2);
        idx = first_diff();
        checks++;
        if (idx != -1) begin
            errors++;
            $display("FAIL b2b_wave cycle %0d tx/busy/done got %b%b%b want %b%b%b", idx,
                     cap_tx[idx], cap_busy[idx], cap_done[idx], exp_tx[idx], exp_busy[idx],
                     exp_done[idx]);
        end
        checks++;
        if (count_ones(cap_done) != 3) begin
            errors++;
            $display("FAIL b2b_done count %0d want 3", count_ones(cap_done));
        end
    endtask

    task automatic test_reset_midframe();
        int idx;
        clear_all();
        kick_s(8'hC0, 8'h50);
        capture(18, -10, 8'h00, 8'h00, -10);
        checks++;
        if (carry_s !== 1'b1) begin errors++; $display("FAIL rstmid_precarry got %b want 1", carry_s); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (tx_s !== 1'b1 || busy_s !== 1'b0 || carry_s !== 1'b0 || done_s !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_abort tx/busy/carry/done got %b%b%b%b want 1000",
                     tx_s, busy_s, carry_s, done_s);
        end
        clear_all();
        capture(45, -10, 8'h00, 8'h00, -10);
        checks++;
        if (count_ones(cap_done) != 0 || count_ones(cap_tx) != 45) begin
            errors++;
            $display("FAIL rstmid_quiet done %0d tx-high %0d want 0 and 45",
                     count_ones(cap_done), count_ones(cap_tx));
        end
        clear_all();
        kick_s(8'h12, 8'h23);
        capture(42, -10, 8'h00, 8'h00, -10);
        model_frame(8'h35); model_idle(1);
        idx = first_diff();
        checks++;
        if (idx != -1) begin
            errors++;
            $display("FAIL rstmid_recover cycle %0d tx/busy/done got %b%b%b want %b%b%b", idx,
                     cap_tx[idx], cap_busy[idx], cap_done[idx], exp_tx[idx], exp_busy[idx],
                     exp_done[idx]);
        end
    endtask

    // Independent UART receiver: find the falling edge, then sample mid-bit.
    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            logic [8:0] sum;
            logic [7:0] rx;
            logic       sbit, pbit, found, got;
            a_l = 8'($urandom_range(0, 255));
            b_l = 8'($urandom_range(0, 255));
            sum = 9'(a_l) + 9'(b_l);
            start_l = 1'b1;
            tick();
            start_l = 1'b0;
            found = 1'b0;
            for (int w = 0; w < 8 && !found; w++) begin
                if (tx_l === 1'b0) found = 1'b1;
                else tick();
            end
            repeat (CPB_L / 2) tick();
            sbit = tx_l;
            for (int k = 0; k < 8; k++) begin
                repeat (CPB_L) tick();
                rx[k] = tx_l;
            end
            repeat (CPB_L) tick();
            pbit = tx_l;
            got = 1'b0;
            for (int w = 0; w < 2 * int'(CPB_L) && !got; w++) begin
                if (done_l === 1'b1) got = 1'b1;
                else tick();
            end
            checks++;
            if (rx !== sum[7:0]) begin
                errors++;
                $display("FAIL rand_byte %0d a=%h b=%h got %h want %h", n, a_l, b_l, rx, sum[7:0]);
            end
            checks++;
            if (carry_l !== sum[8]) begin
                errors++;
                $display("FAIL rand_carry %0d a=%h b=%h got %b want %b", n, a_l, b_l, carry_l,
                         sum[8]);
            end
            checks++;
            if (!found || sbit !== 1'b0 || pbit !== 1'b1 || !got) begin
                errors++;
                $display("FAIL rand_framing %0d edge/start/stop/done got %b%b%b%b want 1011", n,
                         found, sbit, pbit, got);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        start_s = 1'b0; start_l = 1'b0;
        a_s = '0; b_s = '0; a_l = '0; b_l = '0;
        test_reset();
        test_basic();
        test_overflow();
        test_midframe_start();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
